// File: rtl/frame_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_rd_arbiter
// Description : Shares the frame-buffer read port between VGA scan-out and a
//               burst-reading processing unit. VGA owns every slot whose
//               pixel lies inside the camera window (vga_win=1). The
//               processing burst uses every remaining slot, so VGA is never
//               stalled.
// Optional    : FRAME_ARB_STATS_EN - when defined, stall_cnt counts the
//               ISSUE cycles lost to VGA slots. It saturates, clears on
//               burst start and holds in IDLE. Otherwise stall_cnt = 0.
// Ports       : clk, rst          - clock and synchronous active-high reset
//               vga_win/vga_addr  - VGA slot ownership and read address
//               vga_data          - VGA pixel, zero after a processing slot
//               burst_start/addr/len - burst request, accepted in IDLE only
//               busy, burst_done  - burst in progress / end-of-burst pulse
//               rd_valid/rd_data/rd_addr - processing read return
//               stall_cnt         - VGA-blocked cycle count (optional)
//               mem_addr/mem_data - RAM read port, 1-cycle read latency
// Revision    : 1.0 - initial release
// ============================================================================
module frame_rd_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 12,
  parameter int IMA_SIZE = 19200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_win,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_data,
  input  logic          burst_start,
  input  logic [AW-1:0] burst_addr,
  input  logic [AW:0]   burst_len,
  output logic          busy,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic          burst_done,
  output logic [15:0]   stall_cnt,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data
);

  localparam logic [AW:0]   c_IMA_LEN  = (AW+1)'(IMA_SIZE);
  localparam logic [AW-1:0] c_PTR_LAST = AW'(IMA_SIZE - 1);
  localparam logic [AW:0]   c_LEN_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_proc_slot;
  logic          w_accept;
  logic          w_accept_zero;

  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_remain;
  logic          r_zero_done;
  // Return tag: r_tag_vld stays low until the first slot after reset so the
  // read data outputs come up as zero rather than whatever the RAM returns.
  logic          r_tag_vld;
  logic          r_tag_proc;
  logic [AW-1:0] r_tag_addr;

  logic [AW-1:0] w_start_ptr;
  logic [AW:0]   w_start_len;
  logic [AW-1:0] w_ptr_inc;

  assign w_start_ptr = ({1'b0, burst_addr} >= c_IMA_LEN) ? '0 : burst_addr;
  assign w_start_len = (burst_len > c_IMA_LEN) ? c_IMA_LEN : burst_len;
  assign w_ptr_inc   = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and slot decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_proc_slot   = 1'b0;
    w_accept      = 1'b0;
    w_accept_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (burst_start) begin
          if (burst_len != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_accept_zero = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!vga_win) begin
          w_proc_slot = 1'b1;
          if (r_remain == c_LEN_ONE) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst pointer, remaining count and return tag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remain    <= '0;
      r_zero_done <= 1'b0;
      r_tag_vld   <= 1'b0;
      r_tag_proc  <= 1'b0;
      r_tag_addr  <= '0;
    end else begin
      r_zero_done <= w_accept_zero;
      r_tag_vld   <= 1'b1;
      r_tag_proc  <= w_proc_slot;
      r_tag_addr  <= r_ptr;
      if (w_accept) begin
        r_ptr    <= w_start_ptr;
        r_remain <= w_start_len;
      end else if (w_proc_slot) begin
        r_ptr    <= w_ptr_inc;
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  assign mem_addr   = w_proc_slot ? r_ptr : vga_addr;
  assign busy       = (r_state != S_IDLE);
  // The last read returns during DRAIN, so the done pulse lines up with it.
  assign burst_done = (r_state == S_DRAIN) || r_zero_done;
  assign rd_valid   = r_tag_proc;
  assign rd_data    = r_tag_proc ? mem_data : '0;
  assign rd_addr    = r_tag_proc ? r_tag_addr : '0;
  assign vga_data   = (r_tag_vld && !r_tag_proc) ? mem_data : '0;

  // --------------------------------------------------------------------------
  // Optional VGA stall statistics
  // --------------------------------------------------------------------------
`ifdef FRAME_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_accept || w_accept_zero) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_ISSUE) && vga_win && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
